// File: rtl/spi_master_engine_if.sv
// spi_master_engine_if: register-block <-> engine control/data bus plus the SPI pins
interface spi_master_engine_if #(parameter int DATA_W = 8);
  logic spen;
  logic cpol;
  logic cpha;
  logic lsbfe;
  logic [7:0] br;
  logic [DATA_W-1:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic rx_valid;
  logic busy;
  logic sck;
  logic mosi;
  logic miso;
  logic ss_n;
  modport master (
    input spen, cpol, cpha, lsbfe, br, tx_data, tx_valid, miso,
    output tx_ready, rx_data, rx_valid, busy, sck, mosi, ss_n
  );
  modport slave (
    output spen, cpol, cpha, lsbfe, br, tx_data, tx_valid, miso,
    input tx_ready, rx_data, rx_valid, busy, sck, mosi, ss_n
  );
endinterface

// File: rtl/spi_master_engine.sv
// spi_master_engine: byte-serial SPI master with programmable SCK divider and all four modes
module spi_master_engine #(parameter int DATA_W = 8) (
  input logic clk,
  input logic rst,
  spi_master_engine_if.master bus
);
  typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, DONE} state_t;
  localparam logic [7:0] NE = 8'(2 * DATA_W);
  state_t state, nxt;
  logic [9:0] cnt, h_q, h_m1;
  logic [10:0] h_new;
  logic [7:0] edge_cnt, e;
  logic [DATA_W-1:0] sh_tx, sh_rx, rx_q;
  logic c_cpha, c_lsb, sck_r, mosi_r;
  logic act, acc, tick, fire, samp, drive;
  logic unused_br;

  function automatic logic first_bit(input logic [DATA_W-1:0] d, input logic l);
    return l ? d[0] : d[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shifted(input logic [DATA_W-1:0] d, input logic l);
    return l ? d >> 1 : d << 1;
  endfunction

  assign unused_br = bus.br[7] ^ bus.br[3];

  // Edge bookkeeping and next-state: edge e is the SCK edge registered when the half-period expires
  always_comb begin
    h_new = ({8'd0, bus.br[6:4]} + 11'd1) << bus.br[2:0];
    h_m1 = 10'(h_new - 11'd1);
    act = state inside {LEAD, XFER, TRAIL};
    acc = state == IDLE && bus.spen && bus.tx_valid;
    tick = cnt == 10'd0;
    fire = bus.spen && tick && (state == LEAD || state == XFER);
    e = state == LEAD ? 8'd1 : edge_cnt + 8'd1;
    samp = fire && (e[0] ^ c_cpha);
    drive = fire && (c_cpha ? e[0] : (!e[0] && e < NE));
    nxt = (state != IDLE && !bus.spen) ? IDLE :
          state == IDLE  ? (acc ? LEAD : IDLE) :
          state == LEAD  ? (tick ? XFER : LEAD) :
          state == XFER  ? ((tick && e == NE) ? TRAIL : XFER) :
          state == TRAIL ? (tick ? DONE : TRAIL) : IDLE;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end

  // Divider, shift registers and latched transfer configuration
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      h_q <= '0;
      edge_cnt <= '0;
      sh_tx <= '0;
      sh_rx <= '0;
      rx_q <= '0;
      c_cpha <= 1'b0;
      c_lsb <= 1'b0;
      sck_r <= 1'b0;
      mosi_r <= 1'b0;
    end else begin
      cnt <= acc ? h_m1 : act ? (tick ? h_q : cnt - 10'd1) : cnt;
      if (acc) begin
        h_q <= h_m1;
        c_cpha <= bus.cpha;
        c_lsb <= bus.lsbfe;
        edge_cnt <= '0;
        sck_r <= bus.cpol;
        sh_rx <= '0;
        mosi_r <= !bus.cpha && first_bit(bus.tx_data, bus.lsbfe);
        sh_tx <= bus.cpha ? bus.tx_data : shifted(bus.tx_data, bus.lsbfe);
      end
      if (fire) begin
        edge_cnt <= e;
        sck_r <= ~sck_r;
      end
      if (samp) sh_rx <= c_lsb ? {bus.miso, sh_rx[DATA_W-1:1]} : {sh_rx[DATA_W-2:0], bus.miso};
      if (drive) begin
        mosi_r <= first_bit(sh_tx, c_lsb);
        sh_tx <= shifted(sh_tx, c_lsb);
      end
      if (state == TRAIL && tick && bus.spen) rx_q <= sh_rx;
    end
  end

  assign bus.busy = act;
  assign bus.ss_n = !act;
  assign bus.sck = rst ? 1'b0 : act ? sck_r : bus.cpol;
  assign bus.mosi = act & mosi_r;
  assign bus.tx_ready = !rst && state == IDLE && bus.spen;
  assign bus.rx_valid = state == DONE;
  assign bus.rx_data = rx_q;
endmodule

// File: tb/tb_spi_master_engine.sv
// tb_spi_master_engine: randomized SPI transfers checked against a pin-level slave/timing model
module tb_spi_master_engine;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic loop = 1'b0;
  logic miso_s = 1'b0;
  logic [7:0] last_rx = 8'h00;
  logic [1:0] md;
  int n_checks = 0;
  int n_errors = 0;

  spi_master_engine_if #(.DATA_W(8)) bus();
  spi_master_engine #(.DATA_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  assign bus.miso = loop ? bus.mosi : miso_s;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready();
    #1;
    for (int i = 0; i < 40 && !bus.tx_ready; i++) @(negedge clk);
    check("accept", bus.tx_ready, 1);
  endtask

  task automatic xfer(input logic p, input logic ph, input logic l, input logic [7:0] b,
                      input logic [7:0] t, input logic [7:0] s, input logic lp, input bit scr);
    int h, rel, edges, si, lat, bad_sp, bad_bit, bad_drv;
    logic ps, pm, pss, odd, dr;
    h = (int'(b[6:4]) + 1) * (1 << b[2:0]);
    @(negedge clk);
    bus.cpol = p; bus.cpha = ph; bus.lsbfe = l; bus.br = b; bus.tx_data = t; bus.tx_valid = 1'b1;
    loop = lp;
    miso_s = l ? s[0] : s[7];
    wait_ready();
    rel = 0; edges = 0; si = 0; lat = 0; bad_sp = 0; bad_bit = 0; bad_drv = 0;
    ps = bus.sck; pm = bus.mosi; pss = bus.ss_n;
    while (lat == 0 && rel < 17 * h + 20) begin
      @(negedge clk);
      rel++;
      if (rel == 1) begin
        bus.tx_valid = 1'b0;
        check("busy", bus.busy, 1);
        check("ready_low", bus.tx_ready, 0);
        if (scr) begin
          bus.cpol = 1'($urandom); bus.cpha = 1'($urandom); bus.lsbfe = 1'($urandom);
          bus.br = 8'($urandom); bus.tx_data = 8'($urandom);
        end
      end
      if (bus.rx_valid) lat = rel;
      else if (!bus.ss_n && !pss) begin
        if (bus.sck !== ps) begin
          edges++;
          odd = (edges % 2) == 1;
          if (rel != 1 + edges * h) bad_sp++;
          if (odd != ph) begin
            if (si < 8 && pm !== (l ? t[si] : t[7-si])) bad_bit++;
            si++;
            miso_s = si < 8 ? (l ? s[si] : s[7-si]) : 1'b0;
          end
          dr = ph ? odd : (!odd && edges < 16);
          if (bus.mosi !== pm && !dr) bad_drv++;
        end else begin
          if (bus.mosi !== pm) bad_drv++;
          if ((edges == 0 || edges == 16) && bus.sck !== p) bad_sp++;
        end
      end
      ps = bus.sck; pm = bus.mosi; pss = bus.ss_n;
    end
    check("latency", lat, 1 + 17 * h);
    check("rx_data", bus.rx_data, lp ? t : s);
    check("sck_edges", edges, 16);
    check("sample_edges", si, 8);
    check("edge_timing", bad_sp, 0);
    check("mosi_bits", bad_bit, 0);
    check("mosi_change", bad_drv, 0);
    last_rx = lp ? t : s;
    @(negedge clk);
    check("strobe_once", bus.rx_valid, 0);
    check("ready_again", bus.tx_ready, 1);
    check("ss_idle", bus.ss_n, 1);
    check("rx_hold", bus.rx_data, last_rx);
  endtask

  task automatic back_to_back();
    int rel, acc2, nrx, hi;
    int rx_t[2];
    logic [7:0] rx_d[2];
    @(negedge clk);
    bus.cpol = 1'b0; bus.cpha = 1'b0; bus.lsbfe = 1'b0; bus.br = 8'h00;
    bus.tx_data = 8'h01; bus.tx_valid = 1'b1; loop = 1'b1;
    wait_ready();
    rel = 0; acc2 = 0; nrx = 0; hi = 0;
    rx_t[0] = 0; rx_t[1] = 0; rx_d[0] = 0; rx_d[1] = 0;
    while (rel < 45) begin
      @(negedge clk);
      rel++;
      if (rel == 1) bus.tx_data = 8'h80;
      if (acc2 > 0 && rel == acc2 + 1) bus.tx_valid = 1'b0;
      if (bus.rx_valid && nrx < 2) begin
        rx_t[nrx] = rel;
        rx_d[nrx] = bus.rx_data;
        nrx++;
      end
      if (bus.ss_n && rel <= 25) hi++;
      if (acc2 == 0 && bus.tx_ready && bus.tx_valid) acc2 = rel;
    end
    bus.tx_valid = 1'b0;
    check("b2b_accept2", acc2, 19);
    check("b2b_strobes", nrx, 2);
    check("b2b_rx_t0", rx_t[0], 18);
    check("b2b_rx_t1", rx_t[1], 37);
    check("b2b_rx_d0", rx_d[0], 8'h01);
    check("b2b_rx_d1", rx_d[1], 8'h80);
    check("b2b_ss_high", hi, 2);
    last_rx = 8'h80;
  endtask

  task automatic abort_test();
    int nrx;
    @(negedge clk);
    bus.cpol = 1'b1; bus.cpha = 1'b0; bus.lsbfe = 1'b1; bus.br = 8'h00;
    bus.tx_data = 8'($urandom); bus.tx_valid = 1'b1; loop = 1'b1;
    wait_ready();
    @(negedge clk);
    bus.tx_valid = 1'b0;
    repeat (7) @(negedge clk);
    check("abort_e7_sck", bus.sck, 0);
    bus.spen = 1'b0;
    @(negedge clk);
    check("abort_ss", bus.ss_n, 1);
    check("abort_busy", bus.busy, 0);
    check("abort_sck", bus.sck, 1);
    check("abort_mosi", bus.mosi, 0);
    check("abort_ready", bus.tx_ready, 0);
    nrx = 0;
    repeat (30) begin
      if (bus.rx_valid) nrx++;
      @(negedge clk);
    end
    check("abort_no_strobe", nrx, 0);
    check("abort_rx_hold", bus.rx_data, last_rx);
    bus.spen = 1'b1;
  endtask

  task automatic reset_test();
    @(negedge clk);
    bus.cpol = 1'b1; bus.cpha = 1'b1; bus.lsbfe = 1'b1; bus.br = 8'h11;
    bus.tx_data = 8'h5A; bus.tx_valid = 1'b1; loop = 1'b0; miso_s = 1'b1;
    wait_ready();
    @(negedge clk);
    bus.tx_valid = 1'b0;
    repeat (20) @(negedge clk);
    check("pre_rst_busy", bus.busy, 1);
    rst = 1'b1;
    #1;
    check("rst_sck", bus.sck, 0);
    check("rst_ss", bus.ss_n, 1);
    check("rst_mosi", bus.mosi, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_rx_data", bus.rx_data, 0);
    check("rst_ready", bus.tx_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_sck", bus.sck, 1);
    check("post_rst_ready", bus.tx_ready, 1);
    last_rx = 8'h00;
  endtask

  initial begin
    bus.spen = 1'b1; bus.cpol = 1'b1; bus.cpha = 1'b0; bus.lsbfe = 1'b0;
    bus.br = 8'h00; bus.tx_data = 8'h00; bus.tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("init_sck", bus.sck, 0);
    check("init_ss", bus.ss_n, 1);
    check("init_mosi", bus.mosi, 0);
    check("init_busy", bus.busy, 0);
    check("init_rx_valid", bus.rx_valid, 0);
    check("init_rx_data", bus.rx_data, 0);
    check("init_ready", bus.tx_ready, 0);
    rst = 1'b0;
    #1;
    check("idle_sck", bus.sck, 1);
    check("idle_ready", bus.tx_ready, 1);
    xfer(1'b0, 1'b0, 1'b0, 8'h00, 8'hA5, 8'h00, 1'b1, 1'b0);
    xfer(1'b1, 1'b1, 1'b1, 8'h11, 8'h3C, 8'hC3, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      md = 2'(i);
      xfer(md[1], md[0], 1'b0, 8'h00, 8'h96, 8'($urandom), 1'b0, 1'b0);
    end
    back_to_back();
    abort_test();
    reset_test();
    for (int i = 0; i < 12; i++)
      xfer(1'($urandom), 1'($urandom), 1'($urandom),
           {1'b0, 3'($urandom_range(0, 1)), 1'($urandom), 3'($urandom_range(0, 2))},
           8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    xfer(1'b0, 1'b1, 1'b0, 8'h77, 8'h5C, 8'($urandom), 1'b0, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
